// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel, DATA_W-bit valid/ready stream multiplexer.
// Selection is by external select (mode 0) or round-robin (mode 1). Once a
// packet's first beat is accepted, the grant is held until its last beat.
// Output register is fully registered; in_ready is combinational.
// Optional feature: define STREAM_MUX_N_CHAN_ID_EN to add the out_chan port,
// which carries the source channel index alongside each output beat.
`timescale 1ns/1ps

module stream_mux_n #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [$clog2(N_CH)-1:0]    sel,
  input  logic [N_CH*DATA_W-1:0]     in_data,
  input  logic [N_CH-1:0]            in_last,
  input  logic [N_CH-1:0]            in_valid,
  output logic [N_CH-1:0]            in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       out_valid,
`ifdef STREAM_MUX_N_CHAN_ID_EN
  output logic [$clog2(N_CH)-1:0]    out_chan,
`endif
  input  logic                       out_ready
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int unsigned N_U = N_CH;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   grant;
  logic [SEL_W-1:0]   rr_ptr;

  logic               load;
  logic               cand_vld;
  logic [SEL_W-1:0]   cand;
  logic [DATA_W-1:0]  cand_data;
  logic               cand_last;
  logic               xfer;

  // Output register may accept a new beat when empty or being drained.
  assign load = !out_valid || out_ready;

  // Choose the candidate channel: held grant when locked, otherwise by mode.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    case (state)
      IDLE: begin
        if (!mode) begin
          if ((int'(sel) < N_CH) && in_valid[sel]) begin
            cand_vld = 1'b1;
            cand     = sel;
          end
        end else begin
          // Search starts just after the last packet's channel and wraps.
          for (int unsigned k = 1; k <= N_U; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + k) % N_U;
            if (!cand_vld && in_valid[idx]) begin
              cand_vld = 1'b1;
              cand     = SEL_W'(idx);
            end
          end
        end
      end
      LOCKED: begin
        if (in_valid[grant]) begin
          cand_vld = 1'b1;
          cand     = grant;
        end
      end
      default: begin
        cand_vld = 1'b0;
        cand     = '0;
      end
    endcase
  end

  // Route the candidate's beat and raise ready only on that channel.
  always_comb begin
    in_ready  = '0;
    cand_data = in_data[cand*DATA_W +: DATA_W];
    cand_last = in_last[cand];
    xfer      = !rst && cand_vld && load;
    if (xfer) begin
      in_ready[cand] = 1'b1;
    end
  end

  // Output register and packet-lock state; rr_ptr advances only at packet end.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef STREAM_MUX_N_CHAN_ID_EN
      out_chan  <= '0;
`endif
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
    end else begin
      if (load) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= cand_data;
          out_last <= cand_last;
`ifdef STREAM_MUX_N_CHAN_ID_EN
          out_chan <= cand;
`endif
        end
      end
      if (xfer) begin
        case (state)
          IDLE: begin
            if (cand_last) begin
              rr_ptr <= cand;
            end else begin
              state <= LOCKED;
              grant <= cand;
            end
          end
          LOCKED: begin
            if (cand_last) begin
              state  <= IDLE;
              rr_ptr <= grant;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: a 4-channel and a 3-channel instance.
// Expected beats are queued as stimulus is issued; a monitor pops and
// compares each beat accepted downstream.
`timescale 1ns/1ps

module tb_stream_mux_n;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] c;
  } exp_t;

  logic        clk;
  logic        rst;

  // 4-channel instance
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  // 3-channel instance
  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_last3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_last3;
  logic        out_valid3;
  logic        out_ready3;

`ifdef STREAM_MUX_N_CHAN_ID_EN
  logic [1:0]  out_chan;
  logic [1:0]  out_chan3;
`endif

  exp_t q4[$];
  exp_t q3[$];
  int   n_pass;
  int   n_total;
  bit   done;

  stream_mux_n #(.N_CH(4), .DATA_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid),
`ifdef STREAM_MUX_N_CHAN_ID_EN
    .out_chan(out_chan),
`endif
    .out_ready(out_ready)
  );

  stream_mux_n #(.N_CH(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_last(in_last3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_last(out_last3),
    .out_valid(out_valid3),
`ifdef STREAM_MUX_N_CHAN_ID_EN
    .out_chan(out_chan3),
`endif
    .out_ready(out_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [7:0] d, input logic l);
    in_data[i*8 +: 8] = d;
    in_last[i]        = l;
  endtask

  task automatic set_ch3(input int i, input logic [7:0] d, input logic l);
    in_data3[i*8 +: 8] = d;
    in_last3[i]        = l;
  endtask

  task automatic push4(input logic [7:0] d, input logic l, input logic [1:0] c);
    q4.push_back({d, l, c});
  endtask

  task automatic push3(input logic [7:0] d, input logic l, input logic [1:0] c);
    q3.push_back({d, l, c});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    done    = 1'b0;
    rst = 1'b1;
    mode = 1'b1; sel = 2'd0; in_data = 32'h13121110; in_last = 4'b1111;
    in_valid = 4'b1111; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_data3 = '0; in_last3 = '0;
    in_valid3 = '0; out_ready3 = 1'b1;

    fork
      begin : stimulus
        exp_t e;
        // Reset held two cycles with every channel valid
        repeat (2) tick();
        chk("reset in_ready", 32'(in_ready), 32'h0);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h00);
        chk("reset out_valid3", 32'(out_valid3), 32'h0);
        rst = 1'b0;
        #1;

        // Round-robin over single-beat packets: ch0,1,2,3,0
        for (int k = 0; k < 5; k++) push4(8'h10 + 8'(k % 4), 1'b1, 2'(k % 4));
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("rr in_ready beat %0d", k), 32'(in_ready), 32'(1 << (k % 4)));
          tick();
        end
        in_valid = 4'b0000;
        tick();
        chk("rr drain out_valid", 32'(out_valid), 32'h0);

        // External select ch2, two-beat packet
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
        set_ch(2, 8'hA1, 1'b0);
        push4(8'hA1, 1'b0, 2'd2);
        push4(8'hA2, 1'b1, 2'd2);
        #1;
        chk("sel2 in_ready beat1", 32'(in_ready), 32'b0100);
        tick();
        set_ch(2, 8'hA2, 1'b1);
        #1;
        chk("sel2 latency out_data", 32'(out_data), 32'hA1);
        chk("sel2 in_ready beat2", 32'(in_ready), 32'b0100);
        tick();
        in_valid = 4'b0000;
        chk("sel2 out_last", 32'(out_last), 32'h1);
        tick();

        // Packet lock on ch1 with a two-cycle gap and a mode change mid-packet
        mode = 1'b1; in_valid = 4'b0010;
        set_ch(1, 8'hB1, 1'b0);
        set_ch(0, 8'hC0, 1'b1);
        set_ch(3, 8'hC3, 1'b1);
        push4(8'hB1, 1'b0, 2'd1);
        push4(8'hB2, 1'b0, 2'd1);
        push4(8'hB3, 1'b1, 2'd1);
        push4(8'hC3, 1'b1, 2'd3);
        push4(8'hC0, 1'b1, 2'd0);
        #1;
        chk("lock first grant ch1", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b1001; mode = 1'b0; sel = 2'd0;
        #1;
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("lock gap in_ready %0d", k), 32'(in_ready), 32'b0000);
          tick();
        end
        in_valid = 4'b1011;
        set_ch(1, 8'hB2, 1'b0);
        #1;
        chk("lock beat2 in_ready", 32'(in_ready), 32'b0010);
        tick();
        set_ch(1, 8'hB3, 1'b1);
        #1;
        chk("lock beat3 in_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b1001; mode = 1'b1;
        #1;
        chk("after lock grant ch3", 32'(in_ready), 32'b1000);
        tick();
        chk("then grant ch0", 32'(in_ready), 32'b0001);
        tick();
        in_valid = 4'b0000;
        tick();

        // Backpressure: hold three cycles, then resume without loss
        in_valid = 4'b0100;
        set_ch(2, 8'hD0, 1'b1);
        push4(8'hD0, 1'b1, 2'd2);
        push4(8'hD1, 1'b1, 2'd2);
        #1;
        chk("bp first in_ready", 32'(in_ready), 32'b0100);
        tick();
        set_ch(2, 8'hD1, 1'b1);
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("bp stall in_ready %0d", k), 32'(in_ready), 32'h0);
          chk($sformatf("bp stall out_data %0d", k), 32'(out_data), 32'hD0);
          chk($sformatf("bp stall out_valid %0d", k), 32'(out_valid), 32'h1);
          tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp resume in_ready", 32'(in_ready), 32'b0100);
        tick();
        in_valid = 4'b0000;
        chk("bp next out_data", 32'(out_data), 32'hD1);
        tick();

        // 3-channel instance: sel=2 grants, sel=3 is out of range
        sel3 = 2'd2; in_valid3 = 3'b111;
        set_ch3(0, 8'hE0, 1'b1);
        set_ch3(1, 8'hE1, 1'b1);
        set_ch3(2, 8'hE2, 1'b1);
        push3(8'hE2, 1'b1, 2'd2);
        #1;
        chk("n3 sel2 in_ready", 32'(in_ready3), 32'b100);
        tick();
        sel3 = 2'd3;
        #1;
        chk("n3 sel3 in_ready", 32'(in_ready3), 32'b000);
        tick();
        chk("n3 sel3 drained out_valid", 32'(out_valid3), 32'h0);
        in_valid3 = 3'b000;

        // Reset mid-packet discards the held beat and returns to IDLE
        out_ready = 1'b0; in_valid = 4'b0010;
        set_ch(1, 8'h5A, 1'b0);
        tick();
        chk("pre-rst beat held", 32'(out_valid), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst mid-packet out_valid", 32'(out_valid), 32'h0);
        chk("rst mid-packet in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0; out_ready = 1'b1; in_valid = 4'b0100;
        set_ch(2, 8'h6B, 1'b1);
        push4(8'h6B, 1'b1, 2'd2);
        #1;
        chk("post-rst idle grant ch2", 32'(in_ready), 32'b0100);
        tick();
        in_valid = 4'b0000;
        repeat (3) tick();

        chk("dut4 queue drained", 32'(q4.size()), 32'h0);
        chk("dut3 queue drained", 32'(q3.size()), 32'h0);
        done = 1'b1;
      end
      begin : monitor
        exp_t e;
        while (!done) begin
          @(negedge clk);
          if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
              n_total++;
              $display("FAIL dut4 unexpected beat: got %0h expected none", out_data);
            end else begin
              e = q4.pop_front();
              chk("dut4 out_data", 32'(out_data), 32'(e.d));
              chk("dut4 out_last", 32'(out_last), 32'(e.l));
`ifdef STREAM_MUX_N_CHAN_ID_EN
              chk("dut4 out_chan", 32'(out_chan), 32'(e.c));
`endif
            end
          end
          if (!rst && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
              n_total++;
              $display("FAIL dut3 unexpected beat: got %0h expected none", out_data3);
            end else begin
              e = q3.pop_front();
              chk("dut3 out_data", 32'(out_data3), 32'(e.d));
              chk("dut3 out_last", 32'(out_last3), 32'(e.l));
`ifdef STREAM_MUX_N_CHAN_ID_EN
              chk("dut3 out_chan", 32'(out_chan3), 32'(e.c));
`endif
            end
          end
        end
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
